// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage
// Brief    : In-order instruction fetch with a DEPTH-entry buffer and redirect drain.
//            Macro FETCH_ALIGN_CHECK_EN enables the sticky misaligned-redirect flag.
// Revision : 1.0
// ============================================================================
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  input  logic        out_ready,
  output logic        misalign_err
);

  localparam int unsigned c_aw = $clog2(DEPTH);
  localparam int unsigned c_cw = c_aw + 1;
  localparam logic [c_cw:0] c_depth = DEPTH[c_cw:0];

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [31:0]       pc_q, pc_d;
  logic [31:0]       rsp_pc_q, rsp_pc_d;
  logic [c_aw-1:0]   head_q, head_d;
  logic [c_aw-1:0]   tail_q, tail_d;
  logic [c_cw-1:0]   cnt_q, cnt_d;
  logic [c_cw-1:0]   outst_q, outst_d;
  logic [c_cw-1:0]   stale_q, stale_d;
  logic [31:0]       instr_mem [DEPTH];
  logic [31:0]       pc_mem    [DEPTH];

  logic              w_fire;
  logic              w_pop;
  logic              w_redirect;
  logic              w_rsp_take;
  logic              w_push;
  logic [31:0]       w_redir_pc;
  logic [c_cw:0]     w_inflight;

  assign w_inflight     = {1'b0, outst_q} + {1'b0, cnt_q};
  assign imem_req_valid = (state_q == ST_RUN) && (w_inflight < c_depth);
  assign imem_req_addr  = (state_q == ST_RESET) ? 32'd0 : pc_q;
  assign out_valid      = (cnt_q != '0);
  assign out_instr      = out_valid ? instr_mem[head_q] : 32'd0;
  assign out_pc         = out_valid ? pc_mem[head_q]    : 32'd0;

  always_comb begin
    w_fire     = imem_req_valid & imem_req_ready;
    w_pop      = out_valid & out_ready;
    w_redirect = redirect_valid & (state_q != ST_RESET);
    w_redir_pc = {redirect_pc[31:2], 2'b00};
    // A response with nothing in flight is noise and never consumed.
    w_rsp_take = imem_rsp_valid & ((outst_q != '0) | (stale_q != '0));
    w_push     = 1'b0;
    state_d    = state_q;
    pc_d       = pc_q;
    rsp_pc_d   = rsp_pc_q;
    head_d     = head_q;
    tail_d     = tail_q;
    cnt_d      = cnt_q;
    outst_d    = outst_q;
    stale_d    = stale_q;
    case (state_q)
      ST_RESET: state_d = ST_RUN;
      default: begin
        if (w_redirect) begin
          pc_d     = w_redir_pc;
          rsp_pc_d = w_redir_pc;
          head_d   = '0;
          tail_d   = '0;
          cnt_d    = '0;
          outst_d  = '0;
          stale_d  = stale_q + outst_q + c_cw'(w_fire) - c_cw'(w_rsp_take);
          state_d  = (stale_d != '0) ? ST_DRAIN : ST_RUN;
        end else begin
          // Stale responses are always older than live ones, so they drain first.
          if (w_rsp_take) begin
            if (stale_q != '0) stale_d = stale_q - c_cw'(1);
            else               w_push  = 1'b1;
          end
          if (w_fire) pc_d = pc_q + 32'd4;
          if (w_push) rsp_pc_d = rsp_pc_q + 32'd4;
          outst_d = outst_q + c_cw'(w_fire) - c_cw'(w_push);
          cnt_d   = cnt_q + c_cw'(w_push) - c_cw'(w_pop);
          head_d  = head_q + c_aw'(w_pop);
          tail_d  = tail_q + c_aw'(w_push);
          if ((state_q == ST_DRAIN) && (stale_d == '0)) state_d = ST_RUN;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_RESET;
      pc_q     <= RESET_PC;
      rsp_pc_q <= RESET_PC;
      head_q   <= '0;
      tail_q   <= '0;
      cnt_q    <= '0;
      outst_q  <= '0;
      stale_q  <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      rsp_pc_q <= rsp_pc_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      cnt_q    <= cnt_d;
      outst_q  <= outst_d;
      stale_q  <= stale_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && w_push) begin
      instr_mem[tail_q] <= imem_rsp_data;
      pc_mem[tail_q]    <= rsp_pc_q;
    end
  end

`ifdef FETCH_ALIGN_CHECK_EN
  logic mis_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      mis_q <= 1'b0;
    end else if (w_redirect && (redirect_pc[1:0] != 2'b00)) begin
      mis_q <= 1'b1;
    end
  end
  assign misalign_err = mis_q;
`else
  logic w_unused_lsb;
  assign w_unused_lsb = ^redirect_pc[1:0];
  assign misalign_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// Testbench for fetch_stage: directed scenarios plus random latency, backpressure
// and redirects, checked against a flow-level model of fetch/response/decode.
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int DEPTH = 4;
  localparam int T_LIVE = 0, T_STALE = 1, T_ORPHAN = 2;
`ifdef FETCH_ALIGN_CHECK_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_ready;
  logic        misalign_err;

  fetch_stage #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc),
    .out_ready(out_ready), .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
    int          tag;
  } mreq_t;

  mreq_t       mq[$];
  logic [31:0] pop_log[$];
  int          checks = 0, errors = 0;
  int          cyc = 0, lat_min = 1, lat_max = 1;
  int          n_buf = 0, n_fire = 0, n_pop = 0;
  bit          running = 1'b0, exp_mis = 1'b0, inj_spur = 1'b0;
  logic [31:0] exp_req_pc = RESET_PC, exp_out_pc = RESET_PC;

  function automatic logic [31:0] memval(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0001;
  endfunction

  // One clock cycle: check outputs against the model, play memory, advance the model.
  task automatic tick();
    int          n_live = 0, n_stale = 0, rtag = -1;
    bit          fire, pop, redir, exp_rv;
    logic [31:0] rpc;
    mreq_t       m;
    foreach (mq[i]) begin
      if (mq[i].tag == T_LIVE) n_live++;
      else if (mq[i].tag == T_STALE) n_stale++;
    end
    exp_rv = running && (n_stale == 0) && (n_live + n_buf < DEPTH);
    checks++;
    if (imem_req_valid !== exp_rv) begin
      errors++; $display("FAIL req_valid cyc=%0d got=%b exp=%b", cyc, imem_req_valid, exp_rv);
    end
    checks++;
    if (out_valid !== (n_buf > 0)) begin
      errors++; $display("FAIL out_valid cyc=%0d got=%b exp=%b", cyc, out_valid, (n_buf > 0));
    end
    checks++;
    if (misalign_err !== exp_mis) begin
      errors++; $display("FAIL misalign_err cyc=%0d got=%b exp=%b", cyc, misalign_err, exp_mis);
    end

    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'd0;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = memval(mq[0].addr);
      rtag           = mq[0].tag;
      void'(mq.pop_front());
    end else if (inj_spur && mq.size() == 0) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'hDEAD_BEEF;
    end
    inj_spur = 1'b0;

    fire  = (imem_req_valid === 1'b1) && (imem_req_ready === 1'b1);
    pop   = (out_valid === 1'b1) && (out_ready === 1'b1);
    redir = (redirect_valid === 1'b1) && running && (rst === 1'b0);

    if (fire) begin
      checks++;
      if (imem_req_addr !== exp_req_pc) begin
        errors++; $display("FAIL req_addr cyc=%0d got=%h exp=%h", cyc, imem_req_addr, exp_req_pc);
      end
      exp_req_pc = exp_req_pc + 32'd4;
      n_fire++;
      m.addr = imem_req_addr;
      m.due  = cyc + int'($urandom_range(lat_max, lat_min));
      m.tag  = rst ? T_ORPHAN : (redir ? T_STALE : T_LIVE);
      mq.push_back(m);
    end
    if (pop) begin
      checks++;
      if (out_pc !== exp_out_pc || out_instr !== memval(exp_out_pc)) begin
        errors++;
        $display("FAIL pop cyc=%0d got pc=%h instr=%h exp pc=%h instr=%h",
                 cyc, out_pc, out_instr, exp_out_pc, memval(exp_out_pc));
      end
      pop_log.push_back(out_pc);
      exp_out_pc = exp_out_pc + 32'd4;
      if (n_buf > 0) n_buf--;
      n_pop++;
    end

    if (rst) begin
      n_buf      = 0;
      running    = 1'b0;
      exp_mis    = 1'b0;
      exp_req_pc = RESET_PC;
      exp_out_pc = RESET_PC;
      foreach (mq[i]) mq[i].tag = T_ORPHAN;
    end else begin
      if (rtag == T_LIVE && !redir) n_buf++;
      if (redir) begin
        rpc   = {redirect_pc[31:2], 2'b00};
        n_buf = 0;
        foreach (mq[i]) if (mq[i].tag == T_LIVE) mq[i].tag = T_STALE;
        exp_req_pc = rpc;
        exp_out_pc = rpc;
        if (MIS_EN && redirect_pc[1:0] != 2'b00) exp_mis = 1'b1;
      end
      running = 1'b1;
    end

    @(posedge clk);
    #1;
    cyc++;
    redirect_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    redirect_valid = 1'b0;
    tick();
    tick();
    for (int k = 0; k < 16 && mq.size() > 0; k++) tick();
    mq.delete();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    imem_req_ready = 1'b0; out_ready = 1'b0; lat_min = 1; lat_max = 1;
    do_reset();
    checks++;
    if (imem_req_valid !== 1'b0 || imem_req_addr !== 32'd0) begin
      errors++; $display("FAIL reset_req got v=%b a=%h exp v=0 a=0", imem_req_valid, imem_req_addr);
    end
    checks++;
    if (out_valid !== 1'b0 || out_pc !== 32'd0 || out_instr !== 32'd0) begin
      errors++; $display("FAIL reset_out got v=%b pc=%h i=%h exp all 0", out_valid, out_pc, out_instr);
    end
    checks++;
    if (misalign_err !== 1'b0) begin
      errors++; $display("FAIL reset_mis got=%b exp=0", misalign_err);
    end
    tick();
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== RESET_PC) begin
      errors++; $display("FAIL first_req got v=%b a=%h exp v=1 a=%h", imem_req_valid, imem_req_addr, RESET_PC);
    end
    inj_spur = 1'b1;
    tick();
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL spurious_rsp got out_valid=%b exp=0", out_valid);
    end
  endtask

  task automatic test_basic_stream();
    imem_req_ready = 1'b1; out_ready = 1'b1; lat_min = 1; lat_max = 1;
    do_reset();
    tick();
    pop_log.delete();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== RESET_PC + 32'(4 * i)) begin
        errors++; $display("FAIL stream_req%0d got v=%b a=%h exp a=%h", i, imem_req_valid, imem_req_addr, RESET_PC + 32'(4 * i));
      end
      tick();
    end
    for (int k = 0; k < 10 && pop_log.size() < 3; k++) tick();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (pop_log.size() <= i || pop_log[i] !== RESET_PC + 32'(4 * i)) begin
        errors++; $display("FAIL stream_out%0d got n=%0d exp pc=%h", i, pop_log.size(), RESET_PC + 32'(4 * i));
      end
    end
  endtask

  task automatic test_backpressure();
    int f0;
    imem_req_ready = 1'b1; out_ready = 1'b0; lat_min = 1; lat_max = 1;
    do_reset();
    tick();
    f0 = n_fire;
    repeat (10) tick();
    checks++;
    if (n_fire - f0 != DEPTH) begin
      errors++; $display("FAIL bp_count got=%0d exp=%0d", n_fire - f0, DEPTH);
    end
    checks++;
    if (imem_req_valid !== 1'b0) begin
      errors++; $display("FAIL bp_valid got=%b exp=0", imem_req_valid);
    end
    checks++;
    if (out_valid !== 1'b1 || out_pc !== RESET_PC || out_instr !== memval(RESET_PC)) begin
      errors++; $display("FAIL bp_head got v=%b pc=%h i=%h exp pc=%h", out_valid, out_pc, out_instr, RESET_PC);
    end
  endtask

  task automatic test_redirect_drain();
    imem_req_ready = 1'b1; out_ready = 1'b1; lat_min = 3; lat_max = 3;
    do_reset();
    tick();
    tick();
    tick();
    imem_req_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h0000_0100;
    tick();
    checks++;
    if (imem_req_valid !== 1'b0) begin
      errors++; $display("FAIL drain_valid got=%b exp=0", imem_req_valid);
    end
    imem_req_ready = 1'b1;
    for (int k = 0; k < 10 && imem_req_valid !== 1'b1; k++) tick();
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100) begin
      errors++; $display("FAIL drain_req got v=%b a=%h exp a=00000100", imem_req_valid, imem_req_addr);
    end
    for (int k = 0; k < 10 && out_valid !== 1'b1; k++) tick();
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h100) begin
      errors++; $display("FAIL drain_out got v=%b pc=%h exp pc=00000100", out_valid, out_pc);
    end
  endtask

  task automatic test_redirect_pop();
    imem_req_ready = 1'b1; out_ready = 1'b1; lat_min = 1; lat_max = 1;
    do_reset();
    repeat (7) tick();
    checks++;
    if (out_valid !== 1'b1) begin
      errors++; $display("FAIL rp_pre got out_valid=%b exp=1", out_valid);
    end
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL rp_flush got out_valid=%b exp=0", out_valid);
    end
    for (int k = 0; k < 10 && out_valid !== 1'b1; k++) tick();
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h200) begin
      errors++; $display("FAIL rp_out got v=%b pc=%h exp pc=00000200", out_valid, out_pc);
    end
  endtask

  task automatic test_misalign();
    imem_req_ready = 1'b1; out_ready = 1'b1; lat_min = 1; lat_max = 1;
    do_reset();
    repeat (4) tick();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0102;
    tick();
    checks++;
    if (misalign_err !== MIS_EN) begin
      errors++; $display("FAIL mis_flag got=%b exp=%b", misalign_err, MIS_EN);
    end
    for (int k = 0; k < 10 && imem_req_valid !== 1'b1; k++) tick();
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100) begin
      errors++; $display("FAIL mis_req got v=%b a=%h exp a=00000100", imem_req_valid, imem_req_addr);
    end
  endtask

  task automatic test_reset_in_drain();
    imem_req_ready = 1'b1; out_ready = 1'b1; lat_min = 4; lat_max = 4;
    do_reset();
    repeat (4) tick();
    imem_req_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h0000_0300;
    tick();
    checks++;
    if (imem_req_valid !== 1'b0) begin
      errors++; $display("FAIL rid_drain got valid=%b exp=0", imem_req_valid);
    end
    imem_req_ready = 1'b1;
    do_reset();
    tick();
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== RESET_PC) begin
      errors++; $display("FAIL rid_req got v=%b a=%h exp a=%h", imem_req_valid, imem_req_addr, RESET_PC);
    end
    for (int k = 0; k < 12 && out_valid !== 1'b1; k++) tick();
    checks++;
    if (out_valid !== 1'b1 || out_pc !== RESET_PC) begin
      errors++; $display("FAIL rid_out got v=%b pc=%h exp pc=%h", out_valid, out_pc, RESET_PC);
    end
  endtask

  task automatic test_random();
    int p0;
    imem_req_ready = 1'b1; out_ready = 1'b1; lat_min = 1; lat_max = 4;
    do_reset();
    p0 = n_pop;
    for (int t = 0; t < 3000; t++) begin
      imem_req_ready = ($urandom_range(99, 0) < 75);
      out_ready      = ($urandom_range(99, 0) < 70);
      if ($urandom_range(99, 0) < 4) begin
        redirect_valid = 1'b1;
        redirect_pc    = $urandom;
        if ($urandom_range(3, 0) != 0) redirect_pc[1:0] = 2'b00;
        if ($urandom_range(7, 0) == 0) redirect_pc[31:4] = '1;
      end
      if (t == 1500) do_reset();
      tick();
    end
    checks++;
    if (n_pop - p0 < 200) begin
      errors++; $display("FAIL rnd_progress got pops=%0d exp>=200", n_pop - p0);
    end
  endtask

  initial begin
    rst = 1'b1; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'd0;
    redirect_valid = 1'b0; redirect_pc = 32'd0; out_ready = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_basic_stream();
    test_backpressure();
    test_redirect_drain();
    test_redirect_pop();
    test_misalign();
    test_reset_in_drain();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 Parameter DEPTH, default 4: instruction buffer entries and maximum in-flight plus buffered instructions; power of two, 2..16.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 imem_req_valid  output  1  fetch request valid.
REQ-006 imem_req_addr  output  32  word-aligned fetch address.
REQ-007 imem_req_ready  input  1  memory accepts request this cycle.
REQ-008 imem_rsp_valid  input  1  in-order response valid; always accepted.
REQ-009 imem_rsp_data  input  32  fetched instruction word.
REQ-010 redirect_valid  input  1  branch/jump redirect.
REQ-011 redirect_pc  input  32  new fetch address.
REQ-012 out_valid  output  1  buffered instruction available to decode.
REQ-013 out_instr  output  32  instruction at buffer head.
REQ-014 out_pc  output  32  address of out_instr.
REQ-015 out_ready  input  1  decode consumes head this cycle.
REQ-016 misalign_err  output  1  sticky misaligned-redirect flag.

Function
REQ-017 Request transfer: imem_req_valid && imem_req_ready on a rising edge; fetch PC then advances by 4, wrapping modulo 2^32.
REQ-018 imem_req_valid, imem_req_addr, out_valid, out_instr and out_pc shall be driven from registered state only, with no combinational path from any input.
REQ-019 imem_req_valid shall be 1 only in state RUN and only when (outstanding + buffer count) < DEPTH.
REQ-020 Each non-stale response shall be written to the buffer tail with its request address; the buffer shall never overflow.
REQ-021 out_valid = buffer non-empty; head pops on out_valid && out_ready; push and pop in the same cycle shall leave the count unchanged.
REQ-022 Zero-latency bypass is not required: minimum latency from response edge to out_valid is 1 cycle.
REQ-023 FSM states: RESET, RUN, DRAIN.
REQ-024 RESET -> RUN on the first cycle with rst low; no request is issued in RESET.
REQ-025 On redirect_valid in any non-reset state:
- buffer flushed;
- fetch PC := redirect_pc;
- all outstanding requests, including one accepted in the same cycle, become stale.
REQ-026 After a redirect, next state shall be DRAIN if the stale count is nonzero, else RUN.
REQ-027 In DRAIN: no requests issued; responses discarded, each decrementing the stale count; DRAIN -> RUN when the count reaches zero; a further redirect in DRAIN updates the PC and remains in DRAIN.
REQ-028 A response in the redirect cycle shall be treated as stale and discarded.
REQ-029 Redirect and pop in the same cycle: the pop completes (head consumed); the flush takes priority for next-cycle buffer state.
REQ-030 Outstanding and stale counters shall be $clog2(DEPTH)+1 bits wide and shall never underflow; a response with zero outstanding is ignored.

Reset
REQ-031 While rst is high:
- state = RESET;
- fetch PC = RESET_PC;
- buffer empty;
- counters zero;
- imem_req_valid = 0, out_valid = 0;
- out_instr, out_pc, imem_req_addr = 0;
- misalign_err = 0.
REQ-032 Reset asserted mid-operation shall discard all in-flight requests; responses arriving while rst is high are ignored.

Configuration
REQ-033 Macro FETCH_ALIGN_CHECK_EN.
- Defined: a redirect with redirect_pc[1:0] != 0 sets misalign_err (sticky until reset), loads the PC with redirect_pc[1:0] cleared, and fetch continues.
- Undefined: misalign_err is tied 0 and redirect_pc is loaded with bits [1:0] cleared.

Verification
REQ-034 Reset release, imem_req_ready = 1, 1-cycle memory, out_ready = 1 -> requests at 0x0, 0x4, 0x8 on consecutive cycles; out_pc sequence 0x0, 0x4, 0x8 with matching instr.
REQ-035 out_ready = 0 held -> exactly 4 requests issued, then imem_req_valid = 0; out_valid = 1 with out_pc = 0x0 stable.
REQ-036 3-cycle memory latency, redirect to 0x100 with 2 outstanding -> state DRAIN, both stale responses dropped, next request addr = 0x100, first out_pc = 0x100.
REQ-037 Redirect to 0x200 in the same cycle as a response and a pop -> the stale response is never presented; out_pc after the redirect = 0x200.
REQ-038 Redirect to 0x102 with FETCH_ALIGN_CHECK_EN defined -> misalign_err = 1 next cycle, fetch from 0x100; undefined -> misalign_err = 0, fetch from 0x100.
REQ-039 rst pulsed while in DRAIN with 3 outstanding -> next fetch at RESET_PC; late responses ignored; out_valid = 0 until a fresh response arrives.
